fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_prefetch.sv | 124 ++++++++++++
 tb/tb_fetch_prefetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state encoding and default parameters for the prefetch unit
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} fetchState;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_MEM_W = 8;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_RESET_PC = 0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of assembled {pc, word} entries with flush
// Ports: clk, rst (sync, active-high), flush (drops all entries), push/pushData,
// pop, headData (zero when empty), empty, count (current occupancy).
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             pushData,
    input  logic                         pop,
    output logic [WIDTH-1:0]             headData,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic full, doPush, doPop;
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign doPush = push && (!full || pop);
    assign doPop = pop && !empty;
    assign headData = empty ? '0 : mem[rdPtr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop) rdPtr <= nextPtr(rdPtr);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end
endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction prefetcher assembling words from narrow memory beats
// Ports: clk, rst (sync, active-high); out_valid/out_ready/out_data/out_pc to decode;
// redir_valid/redir_pc branch redirect; mem_req/mem_addr/mem_ack/mem_rdata memory side.
// Macro FETCH_BIG_ENDIAN_EN: beat 0 fills the most-significant slice instead of the least.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int MEM_W = DEF_MEM_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [MEM_W-1:0]  mem_rdata
);
    localparam int BEATS = WORD_W / MEM_W;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WORD_W / 8);
    fetchState state;
    logic [BW-1:0] beat, slice;
    logic [ADDR_W-1:0] fetchPc, pendPc;
    logic [WORD_W-1:0] wordBuf, assembled;
    logic [ADDR_W+WORD_W-1:0] headData;
    logic [CW-1:0] fifoCount;
    logic fifoEmpty, lastBeat, push, pop, fillsFifo;
`ifdef FETCH_BIG_ENDIAN_EN
    assign slice = LAST_BEAT - beat;
`else
    assign slice = beat;
`endif
    assign lastBeat = beat == LAST_BEAT;
    // A redirect in the same cycle overrides both the pop and the push of a finishing word.
    assign pop = out_valid && out_ready && !redir_valid;
    assign push = state == FETCH && mem_ack && lastBeat && !redir_valid;
    assign fillsFifo = fifoCount == CW'(DEPTH - 1) && !pop;
    assign out_valid = !fifoEmpty;
    assign {out_pc, out_data} = headData;
    always_comb begin
        assembled = wordBuf;
        assembled[slice*MEM_W +: MEM_W] = mem_rdata;
    end
    fetch_fifo #(.WIDTH(ADDR_W + WORD_W), .DEPTH(DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .flush(redir_valid),
        .push(push),
        .pushData({fetchPc, assembled}),
        .pop(pop),
        .headData(headData),
        .empty(fifoEmpty),
        .count(fifoCount)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat <= '0;
            fetchPc <= RESET_PC;
            pendPc <= '0;
            mem_addr <= RESET_PC;
            mem_req <= 1'b0;
            wordBuf <= '0;
        end else if (redir_valid) begin
            beat <= '0;
            if (mem_req && !mem_ack) begin
                // Outstanding beat must complete before the new address can be issued.
                state <= DRAIN;
                pendPc <= redir_pc;
            end else begin
                state <= FETCH;
                mem_req <= 1'b1;
                fetchPc <= redir_pc;
                mem_addr <= redir_pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    mem_req <= 1'b1;
                end
                FETCH: begin
                    if (mem_ack) begin
                        wordBuf <= assembled;
                        if (lastBeat) begin
                            beat <= '0;
                            fetchPc <= fetchPc + WORD_BYTES;
                            mem_addr <= fetchPc + WORD_BYTES;
                            state <= fillsFifo ? FULL : FETCH;
                            mem_req <= !fillsFifo;
                        end else begin
                            beat <= beat + BW'(1);
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (pop) begin
                        state <= FETCH;
                        mem_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state <= FETCH;
                        fetchPc <= pendPc;
                        mem_addr <= pendPc;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed self-checking bench for fetch_prefetch
module tb_fetch_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [31:0] out_pc;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        ackEn = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_prefetch dut (
        .clk(clk),
        .rst(rst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_pc(out_pc),
        .redir_valid(redir_valid),
        .redir_pc(redir_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    // Memory image: bytes 78,56,34,12 repeating, XORed with address bits [9:2].
    function automatic logic [7:0] memByte(input logic [31:0] a);
        logic [31:0] w = 32'h12345678;
        return w[a[1:0]*8 +: 8] ^ a[9:2];
    endfunction

    // Expected words are written little-endian; swap them for the big-endian build.
    function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef FETCH_BIG_ENDIAN_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    assign mem_rdata = memByte(mem_addr);
    assign mem_ack = mem_req && ackEn;

    task automatic doReset();
        rst = 1'b1;
        ackEn = 1'b1;
        redir_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitValid(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%h exp=0", mem_req); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        doReset();
        repeat (4) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early got=%h exp=0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%h exp=1", out_valid); end
        checks++; if (out_data !== ew(32'h12345678)) begin failures++; $display("FAIL basic_data got=%h exp=%h", out_data, ew(32'h12345678)); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL basic_pc got=%h exp=0", out_pc); end
        repeat (4) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin failures++; $display("FAIL basic_pc2 got=%h/%h exp=1/4", out_valid, out_pc); end
        checks++; if (out_data !== ew(32'h13355779)) begin failures++; $display("FAIL basic_data2 got=%h exp=%h", out_data, ew(32'h13355779)); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        doReset();
        repeat (10) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%h exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h8) begin failures++; $display("FAIL full_addr got=%h exp=8", mem_addr); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL full_head got=%h/%h exp=1/0", out_valid, out_pc); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin failures++; $display("FAIL full_restart got=%h/%h exp=1/8", mem_req, mem_addr); end
        checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL full_head2 got=%h exp=4", out_pc); end
        repeat (5) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_req2 got=%h exp=0", mem_req); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_pc !== 32'h8 || out_data !== ew(32'h1036547A)) begin failures++; $display("FAIL full_word3 got=%h/%h exp=8/%h", out_pc, out_data, ew(32'h1036547A)); end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        doReset();
        repeat (10) @(negedge clk);
        redir_valid = 1'b1;
        redir_pc = 32'h200;
        @(negedge clk);
        redir_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rfull_flush got=%h exp=0", out_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin failures++; $display("FAIL rfull_fetch got=%h/%h exp=1/200", mem_req, mem_addr); end
    endtask

    task automatic test_redirect_drain();
        out_ready = 1'b0;
        doReset();
        repeat (7) @(negedge clk);
        checks++; if (mem_addr !== 32'h6) begin failures++; $display("FAIL drain_setup got=%h exp=6", mem_addr); end
        ackEn = 1'b0;
        redir_valid = 1'b1;
        redir_pc = 32'h100;
        @(negedge clk);
        redir_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_flush got=%h exp=0", out_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h6) begin failures++; $display("FAIL drain_hold1 got=%h/%h exp=1/6", mem_req, mem_addr); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h6) begin failures++; $display("FAIL drain_hold2 got=%h/%h exp=1/6", mem_req, mem_addr); end
        ackEn = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL drain_restart got=%h/%h exp=1/100", mem_req, mem_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_stale got=%h exp=0", out_valid); end
        out_ready = 1'b1;
        waitValid(20);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin failures++; $display("FAIL drain_pc got=%h/%h exp=1/100", out_valid, out_pc); end
        checks++; if (out_data !== ew(32'h52741638)) begin failures++; $display("FAIL drain_data got=%h exp=%h", out_data, ew(32'h52741638)); end
    endtask

    task automatic test_redirect_ack();
        out_ready = 1'b0;
        doReset();
        repeat (6) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || mem_addr !== 32'h5) begin failures++; $display("FAIL rack_setup got=%h/%h exp=1/5", out_valid, mem_addr); end
        out_ready = 1'b1;
        redir_valid = 1'b1;
        redir_pc = 32'h300;
        @(negedge clk);
        redir_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rack_flush got=%h exp=0", out_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin failures++; $display("FAIL rack_fetch got=%h/%h exp=1/300", mem_req, mem_addr); end
        waitValid(20);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin failures++; $display("FAIL rack_pc got=%h/%h exp=1/300", out_valid, out_pc); end
        checks++; if (out_data !== ew(32'hD2F496B8)) begin failures++; $display("FAIL rack_data got=%h exp=%h", out_data, ew(32'hD2F496B8)); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        doReset();
        redir_valid = 1'b1;
        redir_pc = 32'hFFFFFFFC;
        @(negedge clk);
        redir_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_start got=%h/%h exp=1/fffffffc", mem_req, mem_addr); end
        waitValid(20);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_pc got=%h/%h exp=1/fffffffc", out_valid, out_pc); end
        checks++; if (out_data !== ew(32'hEDCBA987)) begin failures++; $display("FAIL wrap_data got=%h exp=%h", out_data, ew(32'hEDCBA987)); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h exp=0", mem_addr); end
        waitValid(20);
        checks++; if (out_pc !== 32'h0 || out_data !== ew(32'h12345678)) begin failures++; $display("FAIL wrap_word2 got=%h/%h exp=0/%h", out_pc, out_data, ew(32'h12345678)); end
    endtask

    task automatic test_reset_midbeat();
        out_ready = 1'b1;
        doReset();
        repeat (3) @(negedge clk);
        ackEn = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2) begin failures++; $display("FAIL mid_stall got=%h/%h exp=1/2", mem_req, mem_addr); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset got=%h/%h/%h exp=0/0/0", mem_req, mem_addr, out_valid); end
        rst = 1'b0;
        ackEn = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL mid_restart got=%h/%h exp=1/0", mem_req, mem_addr); end
        waitValid(20);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_data !== ew(32'h12345678)) begin failures++; $display("FAIL mid_word got=%h/%h/%h exp=1/0/%h", out_valid, out_pc, out_data, ew(32'h12345678)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_redirect_full();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_midbeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
